// File: rtl/wb_uart_debug_master_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_debug_master_if
// Brief    : Byte-stream and Wishbone master signal bundle for the debug master
// Revision : 1.0 - initial release
// ============================================================================
interface wb_uart_debug_master_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;
    logic        busy_o;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        output tx_data_o, tx_valid_o,
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_cti_o, wbm_bte_o, busy_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        input  tx_data_o, tx_valid_o,
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_cti_o, wbm_bte_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_uart_debug_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_debug_master
// Brief    : Byte-stream command parser driving single classic Wishbone cycles
// Revision : 1.0 - initial release
// ============================================================================
module wb_uart_debug_master #(
    parameter int BUS_TIMEOUT = 1024
) (
    input  logic                   clk_i,
    input  logic                   nrst_i,
    wb_uart_debug_master_if.master bus
);
    localparam logic [7:0]  C_CMD_READ  = 8'h52;
    localparam logic [7:0]  C_CMD_WRITE = 8'h57;
    localparam logic [15:0] C_TMO_LAST  = 16'(BUS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_STAT = 3'd4,
        ST_RDAT = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [1:0]  r_cnt;
    logic [31:0] r_adr_sh;
    logic [31:0] r_dat_sh;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [31:0] r_rdat;
    logic [7:0]  r_status;
    logic [15:0] r_tmo;
    logic        r_cyc;

    logic        w_cmd;
    logic        w_last_byte;
    logic        w_done;
    logic        w_hs;
    logic [7:0]  w_status;

    assign w_cmd       = bus.rx_valid_i &&
                         (bus.rx_data_i == C_CMD_READ || bus.rx_data_i == C_CMD_WRITE);
    assign w_last_byte = bus.rx_valid_i && (r_cnt == 2'd3);
    assign w_done      = r_cyc && (bus.wbm_ack_i || bus.wbm_err_i || bus.wbm_rty_i ||
                                   (r_tmo == C_TMO_LAST));
    assign w_hs        = bus.tx_valid_o && bus.tx_ready_i;

    // A real termination in the final counted cycle outranks the timeout code.
    always_comb begin
        w_status = 8'h03;
        if (bus.wbm_err_i)      w_status = 8'h01;
        else if (bus.wbm_rty_i) w_status = 8'h02;
        else if (bus.wbm_ack_i) w_status = 8'h00;
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_cmd)       w_next = ST_ADDR;
            ST_ADDR: if (w_last_byte) w_next = r_we ? ST_DATA : ST_BUS;
            ST_DATA: if (w_last_byte) w_next = ST_BUS;
            ST_BUS:  if (w_done)      w_next = ST_STAT;
            ST_STAT: if (w_hs)        w_next = r_we ? ST_IDLE : ST_RDAT;
            ST_RDAT: if (w_hs && r_cnt == 2'd3) w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    // Shift registers collect the frame so the bus-facing adr/dat only change
    // when a new cycle actually starts.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_we     <= 1'b0;
            r_cnt    <= 2'd0;
            r_adr_sh <= 32'd0;
            r_dat_sh <= 32'd0;
            r_adr    <= 32'd0;
            r_dat    <= 32'd0;
            r_rdat   <= 32'd0;
            r_status <= 8'd0;
            r_tmo    <= 16'd0;
            r_cyc    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd) begin
                        r_we  <= (bus.rx_data_i == C_CMD_WRITE);
                        r_cnt <= 2'd0;
                    end
                end
                ST_ADDR: begin
                    if (bus.rx_valid_i) begin
                        r_adr_sh <= {r_adr_sh[23:0], bus.rx_data_i};
                        r_cnt    <= r_cnt + 2'd1;
                        if (w_last_byte && !r_we) begin
                            r_adr <= {r_adr_sh[23:0], bus.rx_data_i};
                            r_cyc <= 1'b1;
                            r_tmo <= 16'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.rx_valid_i) begin
                        r_dat_sh <= {r_dat_sh[23:0], bus.rx_data_i};
                        r_cnt    <= r_cnt + 2'd1;
                        if (w_last_byte) begin
                            r_adr <= r_adr_sh;
                            r_dat <= {r_dat_sh[23:0], bus.rx_data_i};
                            r_cyc <= 1'b1;
                            r_tmo <= 16'd0;
                        end
                    end
                end
                ST_BUS: begin
                    if (w_done) begin
                        r_cyc    <= 1'b0;
                        r_status <= w_status;
                        r_rdat   <= (w_status == 8'h00) ? bus.wbm_dat_i : 32'd0;
                        r_cnt    <= 2'd0;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                ST_RDAT: begin
                    if (w_hs) begin
                        r_rdat <= {r_rdat[23:0], 8'h00};
                        r_cnt  <= r_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_valid_o = (r_state == ST_STAT) || (r_state == ST_RDAT);
    assign bus.tx_data_o  = (r_state == ST_STAT) ? r_status :
                            (r_state == ST_RDAT) ? r_rdat[31:24] : 8'h00;

    assign bus.wbm_adr_o = r_adr;
    assign bus.wbm_dat_o = r_dat;
    assign bus.wbm_sel_o = {4{r_cyc}};
    assign bus.wbm_we_o  = r_cyc && r_we;
    assign bus.wbm_cyc_o = r_cyc;
    assign bus.wbm_stb_o = r_cyc;
    assign bus.wbm_cti_o = 3'b000;
    assign bus.wbm_bte_o = 2'b00;
    assign bus.busy_o    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_debug_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_uart_debug_master
// Brief    : Randomized self-checking bench with a frame-level response model
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_uart_debug_master;
    localparam int TMO = 16;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    wb_uart_debug_master_if bus ();

    wb_uart_debug_master #(.BUS_TIMEOUT(TMO)) dut (
        .clk_i  (clk),
        .nrst_i (nrst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Slave behaviour: 0 ack, 1 err, 2 rty, 3 err+ack, 4 rty+ack, 5 silent, 6 err+rty
    int          sl_mode  = 0;
    int          sl_delay = 0;
    logic [31:0] sl_rdata = 32'd0;
    int          cyc_len  = 0;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;

    initial begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_rty_i = 1'b0;
        bus.wbm_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            bus.wbm_rty_i = 1'b0;
            bus.wbm_dat_i = $urandom;
            if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
                if (cyc_len == 0) begin
                    cap_adr = bus.wbm_adr_o;
                    cap_dat = bus.wbm_dat_o;
                    cap_we  = bus.wbm_we_o;
                    cap_sel = bus.wbm_sel_o;
                end
                cyc_len++;
                if (sl_mode != 5 && cyc_len == sl_delay + 1) begin
                    case (sl_mode)
                        0: begin bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = sl_rdata; end
                        1: bus.wbm_err_i = 1'b1;
                        2: bus.wbm_rty_i = 1'b1;
                        3: begin bus.wbm_err_i = 1'b1; bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = sl_rdata; end
                        4: begin bus.wbm_rty_i = 1'b1; bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = sl_rdata; end
                        default: begin bus.wbm_err_i = 1'b1; bus.wbm_rty_i = 1'b1; end
                    endcase
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.rx_valid_i = 1'b0;
            bus.rx_data_i  = 8'($urandom);
        end
        @(negedge clk);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
    endtask

    // rdy_mode: 0 always ready, 1 alternate 1-0-1 on valid cycles, 2 random
    task automatic run_frame(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input int mode, input int delay, input logic [31:0] rdata,
                             input int rdy_mode, input logic inject, input string name);
        logic [7:0]  exp_q[$];
        logic [31:0] tmp;
        logic [7:0]  stat;
        logic [7:0]  hd;
        logic        held;
        logic        injected;
        int          idx, waited, vcnt, exp_len;
        sl_mode  = mode;
        sl_delay = delay;
        sl_rdata = rdata;
        cyc_len  = 0;
        bus.tx_ready_i = 1'b0;

        send_byte(we ? 8'h57 : 8'h52, $urandom_range(0, 2));
        tmp = adr;
        for (int k = 0; k < 4; k++) begin send_byte(tmp[31:24], $urandom_range(0, 2)); tmp = tmp << 8; end
        if (we) begin
            tmp = dat;
            for (int k = 0; k < 4; k++) begin send_byte(tmp[31:24], $urandom_range(0, 2)); tmp = tmp << 8; end
        end
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
        total++;
        if (bus.wbm_stb_o !== 1'b1 || bus.wbm_cyc_o !== 1'b1) begin
            bad++;
            $display("FAIL %s stb_latency: stb=%b cyc=%b required 1", name, bus.wbm_stb_o, bus.wbm_cyc_o);
        end

        case (mode)
            0:       stat = 8'h00;
            2, 4:    stat = 8'h02;
            5:       stat = 8'h03;
            default: stat = 8'h01;
        endcase
        exp_q.push_back(stat);
        if (!we) begin
            tmp = (mode == 0) ? rdata : 32'd0;
            for (int k = 0; k < 4; k++) begin exp_q.push_back(tmp[31:24]); tmp = tmp << 8; end
        end
        exp_len = (mode == 5) ? TMO : delay + 1;

        idx = 0; waited = 0; vcnt = 0; held = 1'b0; hd = 8'h00; injected = 1'b0;
        while (idx < exp_q.size() && waited < 300) begin
            bus.rx_valid_i = 1'b0;
            if (inject && idx == 2 && !injected) begin
                bus.rx_valid_i = 1'b1;
                bus.rx_data_i  = 8'h52;
                injected = 1'b1;
            end
            if (held) begin
                total++;
                if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== hd) begin
                    bad++;
                    $display("FAIL %s tx_hold: valid=%b data=%h required 1/%h", name, bus.tx_valid_o, bus.tx_data_o, hd);
                end
            end
            if (bus.tx_valid_o === 1'b1) begin
                if (bus.wbm_cyc_o !== 1'b0) begin
                    total++; bad++;
                    $display("FAIL %s cyc_during_tx: cyc=%b required 0", name, bus.wbm_cyc_o);
                end
                case (rdy_mode)
                    0:       bus.tx_ready_i = 1'b1;
                    1:       bus.tx_ready_i = (vcnt % 2 == 0);
                    default: bus.tx_ready_i = 1'($urandom_range(0, 1));
                endcase
                vcnt++;
                if (bus.tx_ready_i) begin
                    total++;
                    if (bus.tx_data_o !== exp_q[idx]) begin
                        bad++;
                        $display("FAIL %s tx_byte%0d: got %h required %h", name, idx, bus.tx_data_o, exp_q[idx]);
                    end
                    idx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd   = bus.tx_data_o;
                end
            end else begin
                bus.tx_ready_i = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            waited++;
        end
        bus.tx_ready_i = 1'b0;
        bus.rx_valid_i = 1'b0;
        if (idx < exp_q.size()) begin
            total++; bad++;
            $display("FAIL %s tx_timeout: got %0d bytes required %0d", name, idx, exp_q.size());
        end
        total++;
        if (bus.busy_o !== 1'b0 || bus.tx_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after: busy=%b tx_valid=%b required 0/0", name, bus.busy_o, bus.tx_valid_o);
        end
        total++;
        if (cyc_len !== exp_len) begin
            bad++;
            $display("FAIL %s cyc_len: got %0d required %0d", name, cyc_len, exp_len);
        end
        total++;
        if (cap_adr !== adr || cap_we !== we || cap_sel !== 4'hF || (we && cap_dat !== dat)) begin
            bad++;
            $display("FAIL %s bus_fields: adr=%h we=%b sel=%h dat=%h required %h/%b/f/%h",
                     name, cap_adr, cap_we, cap_sel, cap_dat, adr, we, dat);
        end
        total++;
        if (bus.wbm_we_o !== 1'b0 || bus.wbm_adr_o !== adr) begin
            bad++;
            $display("FAIL %s post_hold: we=%b adr=%h required 0/%h", name, bus.wbm_we_o, bus.wbm_adr_o, adr);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        bus.tx_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.tx_valid_o !== 1'b0 ||
            bus.busy_o !== 1'b0 || bus.wbm_adr_o !== 32'd0 || bus.wbm_dat_o !== 32'd0 ||
            bus.wbm_we_o !== 1'b0 || bus.wbm_sel_o !== 4'h0 || bus.tx_data_o !== 8'h00 ||
            bus.wbm_cti_o !== 3'b000 || bus.wbm_bte_o !== 2'b00) begin
            bad++;
            $display("FAIL reset_state: cyc=%b stb=%b txv=%b busy=%b adr=%h dat=%h required all zero",
                     bus.wbm_cyc_o, bus.wbm_stb_o, bus.tx_valid_o, bus.busy_o, bus.wbm_adr_o, bus.wbm_dat_o);
        end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        run_frame(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 2, 32'd0, 0, 1'b0, "write");
    endtask

    task automatic test_read();
        run_frame(1'b0, 32'h0000_0100, 32'd0, 0, 1, 32'h1234_5678, 1, 1'b0, "read");
    endtask

    task automatic test_err_ack();
        run_frame(1'b0, 32'h0000_0200, 32'd0, 3, 0, 32'hCAFE_F00D, 2, 1'b0, "err_ack");
        run_frame(1'b0, 32'h0000_0204, 32'd0, 0, 3, 32'hA5A5_5A5A, 2, 1'b0, "ack_after_err");
        run_frame(1'b1, 32'h1000_0000, 32'h0BAD_CAFE, 4, 1, 32'd0, 0, 1'b0, "rty_ack");
        run_frame(1'b0, 32'h1000_0004, 32'd0, 6, 2, 32'd0, 0, 1'b0, "err_rty");
    endtask

    task automatic test_timeout();
        run_frame(1'b0, 32'hFFFF_FFF0, 32'd0, 5, 0, 32'd0, 2, 1'b0, "timeout");
        run_frame(1'b0, 32'hFFFF_FFF4, 32'd0, 0, TMO - 1, 32'h7777_8888, 0, 1'b0, "ack_at_limit");
    endtask

    task automatic test_ignored();
        cyc_len = 0;
        send_byte(8'h41, 0);
        send_byte(8'hFF, 0);
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (bus.busy_o !== 1'b0 || cyc_len !== 0) begin
            bad++;
            $display("FAIL ignored_bytes: busy=%b cycles=%0d required 0/0", bus.busy_o, cyc_len);
        end
        run_frame(1'b0, 32'h0000_0300, 32'd0, 0, 0, 32'h0102_0304, 0, 1'b1, "rdat_drop");
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL rdat_drop_idle: busy=%b required 0", bus.busy_o);
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h57, 0);
        for (int k = 0; k < 6; k++) send_byte(8'(k + 1), 0);
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
        #2 nrst = 1'b0;
        #1;
        total++;
        if (bus.busy_o !== 1'b0 || bus.wbm_cyc_o !== 1'b0 || bus.tx_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_data: busy=%b cyc=%b txv=%b required 0", bus.busy_o, bus.wbm_cyc_o, bus.tx_valid_o);
        end
        @(negedge clk);
        nrst = 1'b1;

        sl_mode = 5;
        cyc_len = 0;
        send_byte(8'h52, 0);
        for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k), 0);
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.wbm_stb_o !== 1'b1) begin
            bad++;
            $display("FAIL stb_before_reset: stb=%b required 1", bus.wbm_stb_o);
        end
        #2 nrst = 1'b0;
        #1;
        total++;
        if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.tx_valid_o !== 1'b0 ||
            bus.busy_o !== 1'b0 || bus.wbm_adr_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_in_bus: cyc=%b stb=%b txv=%b busy=%b adr=%h required 0",
                     bus.wbm_cyc_o, bus.wbm_stb_o, bus.tx_valid_o, bus.busy_o, bus.wbm_adr_o);
        end
        @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (bus.tx_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_resp: tx_valid=%b required 0", bus.tx_valid_o);
        end
        run_frame(1'b1, 32'h2000_0010, 32'h5566_7788, 0, 0, 32'd0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_frame(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 6),
                      $urandom_range(0, TMO - 1), $urandom, 2, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_frame(1'b0, 32'h0000_0400, 32'd0, 0, 0, 32'hFEDC_BA98, 0, 1'b0, "b2b_0");
        run_frame(1'b1, 32'h0000_0404, 32'h1111_2222, 1, 0, 32'd0, 0, 1'b0, "b2b_1");
        run_frame(1'b0, 32'h0000_0408, 32'd0, 2, 0, 32'd0, 0, 1'b0, "b2b_2");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_err_ack();
        test_timeout();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_uart_debug_master.md
Name: wb_uart_debug_master

Overview:
- Wishbone single-cycle bus master driven by a byte stream, normally the received-byte side of a host-facing UART.
- Parses read and write command frames, performs one classic Wishbone cycle per frame, then returns a status byte and any read data as a byte stream.
- Fills the SoC's unused debug master slot on the bus matrix, so a host can peek and poke RAM, ROM, the UART and firmware-interface registers without the CPU.

Parameters:
BUS_TIMEOUT, 1024, number of cycles to wait for ack/err/rty after asserting stb before the cycle is aborted; must be 2..65535.

Ports:
clk_i  input  1  system clock
nrst_i  input  1  asynchronous active-low reset
rx_data_i  input  8  incoming command byte
rx_valid_i  input  1  one-cycle strobe; rx_data_i is valid this cycle
tx_data_o  output  8  outgoing response byte
tx_valid_o  output  1  response byte valid; held until accepted
tx_ready_i  input  1  byte sink accepts tx_data_o when tx_valid_o and tx_ready_i are both high
wbm_adr_o  output  32  Wishbone address
wbm_dat_o  output  32  Wishbone write data
wbm_sel_o  output  4  byte selects, always 4'hF during a cycle
wbm_we_o  output  1  write enable
wbm_cyc_o  output  1  cycle
wbm_stb_o  output  1  strobe
wbm_cti_o  output  3  always 3'b000 (classic)
wbm_bte_o  output  2  always 2'b00
wbm_dat_i  input  32  Wishbone read data
wbm_ack_i  input  1  acknowledge
wbm_err_i  input  1  error
wbm_rty_i  input  1  retry
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset: asynchronous on nrst_i low. All outputs go to 0 and the FSM goes to IDLE. Reset mid-frame or mid-cycle drops cyc/stb immediately with no response.
- Frame format:
  - Read frame: 0x52 ('R') followed by 4 address bytes, MSB first.
  - Write frame: 0x57 ('W') followed by 4 address bytes, MSB first, then 4 data bytes, MSB first.
- The address is passed to wbm_adr_o unmodified. No alignment check is made.
- FSM states and transitions:
  - IDLE: on rx_valid_i with 0x52 or 0x57, latch we, clear the byte counter and go to ADDR. Any other byte is ignored and the FSM stays in IDLE.
  - ADDR: each rx_valid_i shifts a byte into adr (adr <= {adr[23:0], byte}). After the 4th byte, a write goes to DATA and a read goes to BUS.
  - DATA: same shifting into dat. After the 4th byte, go to BUS.
  - BUS: cyc and stb are asserted starting the cycle after the last byte is received. They drop in the cycle after the first of ack, err, rty or timeout. Read data is captured on ack. Then go to STAT.
  - STAT: present the status byte. On handshake, a read goes to RDAT and a write goes to IDLE.
  - RDAT: present 4 read-data bytes, MSB first, one per handshake. After the 4th, go to IDLE.
- Status codes: 0x00 = ack, 0x01 = err, 0x02 = rty, 0x03 = timeout.
- Simultaneous terminations: priority is err > rty > ack.
- Timeout:
  - The counter starts at 0 in the first BUS cycle and increments every cycle cyc is high.
  - When it reaches BUS_TIMEOUT-1 with no termination, cyc/stb drop and the status is 0x03.
  - A termination in that same cycle wins over the timeout.
- Read data on non-ack: if a read ends in err, rty or timeout, RDAT still sends 4 bytes, all 0x00.
- No retry is attempted on rty; the host re-issues the frame.
- Bytes received in BUS, STAT or RDAT are dropped silently.
- Latency:
  - Last rx byte at cycle N puts stb high at N+1.
  - Ack at cycle M drops cyc at M+1 and raises tx_valid_o with the status at M+1.
- TX handshake:
  - tx_data_o is stable while tx_valid_o is high and not yet accepted.
  - After a handshake, the next byte may be valid in the following cycle.
  - tx_valid_o stays low outside STAT and RDAT.
- Output values:
  - wbm_adr_o and wbm_dat_o hold their last values between cycles.
  - wbm_we_o is 0 whenever cyc is low.

Test Plan:
- Write 57 00 00 01 00 DE AD BE EF, slave acks after 2 cycles → one cycle with adr=0x00000100, dat=0xDEADBEEF, we=1, sel=F; tx byte 0x00; busy_o returns to 0.
- Read 52 00 00 01 00, slave acks with 0x12345678 → we=0; tx sequence 00 12 34 56 78, with tx_ready_i toggled 1-0-1 to check that held data stays stable.
- Read with the slave asserting err and ack in the same cycle → tx 01 00 00 00 00; a following ack-only read of another address returns 00 plus that address's data.
- BUS_TIMEOUT=16 with a silent slave → cyc high for exactly 16 cycles; tx 03 00 00 00 00.
- Bytes 0x41 then 0xFF in IDLE → ignored, no bus activity; 0x52 sent during RDAT → dropped, and the FSM still returns to IDLE after 4 data bytes.
- nrst_i pulsed low while stb is high and while in DATA → cyc/stb/tx_valid_o go to 0 immediately; a fresh frame after reset completes normally.
